// File: rtl/grid_ccff_bank_if.sv
// Serial configuration-chain bundle between a tile's config bank and its driver.
// The master modport drives the shift/commit controls; the bank is the slave.
interface grid_ccff_bank_if #(
    parameter int NUM_BITS = 64,
    parameter int CNT_W    = $clog2(NUM_BITS + 1)
);
    logic                ccff_head;
    logic                ccff_shift_en;
    logic                cfg_commit;
    logic                ccff_tail;
    logic [NUM_BITS-1:0] mem_out;
    logic [NUM_BITS-1:0] mem_outb;
    logic                cfg_done;
    logic                cfg_valid;
    logic                cfg_err;
    logic [CNT_W-1:0]    bit_count;

    modport master (
        output ccff_head, ccff_shift_en, cfg_commit,
        input  ccff_tail, mem_out, mem_outb, cfg_done, cfg_valid, cfg_err, bit_count
    );

    modport slave (
        input  ccff_head, ccff_shift_en, cfg_commit,
        output ccff_tail, mem_out, mem_outb, cfg_done, cfg_valid, cfg_err, bit_count
    );
endinterface

// File: rtl/grid_ccff_bank.sv
// Double-buffered configuration flip-flop bank: a never-stalling serial shift chain
// plus a committed copy. Optional macro CCFF_PARITY_EN gates commits on even parity.
module grid_ccff_bank #(
    parameter int NUM_BITS = 64,
    parameter int CNT_W    = $clog2(NUM_BITS + 1)
) (
    input  logic             prog_clk,
    input  logic             prog_reset,
    grid_ccff_bank_if.slave  bus
);
    typedef enum logic [1:0] {EMPTY, LOADING, LOADED} state_t;

    localparam logic [CNT_W-1:0] FULL = CNT_W'(NUM_BITS);

    state_t              state, state_nxt;
    logic [NUM_BITS-1:0] sr, mem;
    logic [CNT_W-1:0]    cnt, cnt_nxt, cnt_inc;
    logic                valid, err, err_nxt;
    logic                shift, commit_ok;

    assign shift   = bus.ccff_shift_en;
    assign cnt_inc = cnt + CNT_W'(1);

`ifdef CCFF_PARITY_EN
    assign commit_ok = bus.cfg_commit && (state == LOADED) && !(^sr);
`else
    assign commit_ok = bus.cfg_commit && (state == LOADED);
`endif

    // The chain shifts regardless of state so downstream tiles are never starved.
    always_ff @(posedge prog_clk or negedge prog_reset) begin
        if (!prog_reset) sr <= '0;
        else if (shift)  sr <= {sr[NUM_BITS-2:0], bus.ccff_head};
    end

    always_ff @(posedge prog_clk or negedge prog_reset) begin
        if (!prog_reset) begin
            state <= EMPTY;
            cnt   <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            err   <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        err_nxt   = err;
        if (bus.cfg_commit && !commit_ok) err_nxt = 1'b1;
        if (commit_ok) begin
            // A shift coinciding with the commit becomes bit 1 of the next frame.
            state_nxt = shift ? LOADING : EMPTY;
            cnt_nxt   = shift ? CNT_W'(1) : '0;
        end else if (shift) begin
            case (state)
                EMPTY, LOADING: begin
                    cnt_nxt   = cnt_inc;
                    state_nxt = (cnt_inc == FULL) ? LOADED : LOADING;
                end
                default: err_nxt = 1'b1;
            endcase
        end
    end

    // Commit captures the pre-shift chain contents.
    always_ff @(posedge prog_clk or negedge prog_reset) begin
        if (!prog_reset) begin
            mem   <= '0;
            valid <= 1'b0;
        end else if (commit_ok) begin
            mem   <= sr;
            valid <= 1'b1;
        end
    end

    assign bus.ccff_tail = sr[NUM_BITS-1];
    assign bus.mem_out   = mem;
    assign bus.mem_outb  = ~mem;
    assign bus.cfg_done  = (state == LOADED);
    assign bus.cfg_valid = valid;
    assign bus.cfg_err   = err;
    assign bus.bit_count = cnt;
endmodule

// File: tb/tb_grid_ccff_bank.sv
// Directed bench for grid_ccff_bank at NUM_BITS=8; parity expectations follow CCFF_PARITY_EN.
module tb_grid_ccff_bank;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    grid_ccff_bank_if #(.NUM_BITS(8)) bus ();

    grid_ccff_bank #(.NUM_BITS(8)) dut (
        .prog_clk   (clk),
        .prog_reset (rst_n),
        .bus        (bus)
    );

    task automatic do_reset();
        bus.ccff_head = 1'b0; bus.ccff_shift_en = 1'b0; bus.cfg_commit = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic shift_bit(input logic b);
        bus.ccff_head = b; bus.ccff_shift_en = 1'b1;
        @(posedge clk); #1;
        bus.ccff_shift_en = 1'b0;
    endtask

    task automatic shift_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) shift_bit(v[i]);
    endtask

    task automatic commit();
        bus.cfg_commit = 1'b1;
        @(posedge clk); #1;
        bus.cfg_commit = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.ccff_tail !== 1'b0) begin errors++; $display("FAIL reset_tail: got %b want 0", bus.ccff_tail); end
        checks++; if (bus.mem_out !== 8'h00) begin errors++; $display("FAIL reset_mem_out: got %h want 00", bus.mem_out); end
        checks++; if (bus.mem_outb !== 8'hFF) begin errors++; $display("FAIL reset_mem_outb: got %h want ff", bus.mem_outb); end
        checks++; if ({bus.cfg_done, bus.cfg_valid, bus.cfg_err} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got %b want 000", {bus.cfg_done, bus.cfg_valid, bus.cfg_err}); end
        checks++; if (bus.bit_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.bit_count); end
    endtask

    task automatic test_shift();
        logic [7:0] v;
        v = 8'hA5;
        for (int i = 7; i >= 1; i--) shift_bit(v[i]);
        checks++; if (bus.cfg_done !== 1'b0) begin errors++; $display("FAIL shift_done_early: got %b want 0", bus.cfg_done); end
        checks++; if (bus.bit_count !== 4'd7) begin errors++; $display("FAIL shift_count7: got %0d want 7", bus.bit_count); end
        shift_bit(v[0]);
        checks++; if (bus.cfg_done !== 1'b1) begin errors++; $display("FAIL shift_done: got %b want 1", bus.cfg_done); end
        checks++; if (bus.bit_count !== 4'd8) begin errors++; $display("FAIL shift_count8: got %0d want 8", bus.bit_count); end
        checks++; if (bus.mem_out !== 8'h00) begin errors++; $display("FAIL shift_mem_hold: got %h want 00", bus.mem_out); end
        checks++; if (bus.cfg_err !== 1'b0) begin errors++; $display("FAIL shift_err: got %b want 0", bus.cfg_err); end
    endtask

    task automatic test_commit();
        commit();
        checks++; if (bus.mem_out !== 8'hA5) begin errors++; $display("FAIL commit_mem_out: got %h want a5", bus.mem_out); end
        checks++; if (bus.mem_outb !== 8'h5A) begin errors++; $display("FAIL commit_mem_outb: got %h want 5a", bus.mem_outb); end
        checks++; if (bus.cfg_valid !== 1'b1) begin errors++; $display("FAIL commit_valid: got %b want 1", bus.cfg_valid); end
        checks++; if (bus.bit_count !== 4'd0) begin errors++; $display("FAIL commit_count: got %0d want 0", bus.bit_count); end
        checks++; if (bus.cfg_done !== 1'b0) begin errors++; $display("FAIL commit_done: got %b want 0", bus.cfg_done); end
    endtask

    task automatic test_early_commit();
        shift_bit(1'b1); shift_bit(1'b1); shift_bit(1'b0);
        commit();
        checks++; if (bus.cfg_err !== 1'b1) begin errors++; $display("FAIL early_err: got %b want 1", bus.cfg_err); end
        checks++; if (bus.mem_out !== 8'hA5) begin errors++; $display("FAIL early_mem_hold: got %h want a5", bus.mem_out); end
        checks++; if (bus.bit_count !== 4'd3) begin errors++; $display("FAIL early_count: got %0d want 3", bus.bit_count); end
        shift_bit(1'b0);
        checks++; if (bus.cfg_err !== 1'b1) begin errors++; $display("FAIL early_err_sticky: got %b want 1", bus.cfg_err); end
    endtask

    task automatic test_pass_through();
        logic [15:0] stream;
        logic [7:0]  tail_seen;
        do_reset();
        stream = 16'hA53C;
        tail_seen = '0;
        for (int k = 1; k <= 16; k++) begin
            // Tail observed during cycle k, i.e. before the k-th shift edge.
            if (k >= 9) tail_seen = {tail_seen[6:0], bus.ccff_tail};
            shift_bit(stream[16-k]);
        end
        checks++; if (tail_seen !== 8'hA5) begin errors++; $display("FAIL pass_tail: got %h want a5", tail_seen); end
        checks++; if (bus.bit_count !== 4'd8) begin errors++; $display("FAIL pass_count_sat: got %0d want 8", bus.bit_count); end
        checks++; if (bus.cfg_err !== 1'b1) begin errors++; $display("FAIL pass_overrun_err: got %b want 1", bus.cfg_err); end
        commit();
        checks++; if (bus.mem_out !== 8'h3C) begin errors++; $display("FAIL pass_mem_out: got %h want 3c", bus.mem_out); end
    endtask

    task automatic test_overrun();
        do_reset();
        shift_byte(8'h5A);
        checks++; if (bus.cfg_err !== 1'b0) begin errors++; $display("FAIL overrun_pre_err: got %b want 0", bus.cfg_err); end
        shift_bit(1'b1);
        checks++; if (bus.cfg_err !== 1'b1) begin errors++; $display("FAIL overrun_err: got %b want 1", bus.cfg_err); end
        checks++; if (bus.cfg_done !== 1'b1) begin errors++; $display("FAIL overrun_done: got %b want 1", bus.cfg_done); end
        checks++; if (bus.bit_count !== 4'd8) begin errors++; $display("FAIL overrun_count: got %0d want 8", bus.bit_count); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        shift_byte(8'h3C);
        bus.cfg_commit = 1'b1; bus.ccff_head = 1'b1; bus.ccff_shift_en = 1'b1;
        @(posedge clk); #1;
        bus.cfg_commit = 1'b0; bus.ccff_shift_en = 1'b0;
        checks++; if (bus.mem_out !== 8'h3C) begin errors++; $display("FAIL simul_mem_out: got %h want 3c", bus.mem_out); end
        checks++; if (bus.bit_count !== 4'd1) begin errors++; $display("FAIL simul_count: got %0d want 1", bus.bit_count); end
        checks++; if (bus.cfg_done !== 1'b0) begin errors++; $display("FAIL simul_done: got %b want 0", bus.cfg_done); end
        checks++; if (bus.cfg_err !== 1'b0) begin errors++; $display("FAIL simul_err: got %b want 0", bus.cfg_err); end
        checks++; if (bus.cfg_valid !== 1'b1) begin errors++; $display("FAIL simul_valid: got %b want 1", bus.cfg_valid); end
        for (int i = 0; i < 7; i++) shift_bit(1'b0);
        checks++; if (bus.cfg_done !== 1'b1) begin errors++; $display("FAIL simul_next_frame_done: got %b want 1", bus.cfg_done); end
    endtask

    task automatic test_midframe_reset();
        // Starts from the LOADED state left by test_simultaneous, mem_out=3c.
        commit();
        shift_bit(1'b1); shift_bit(1'b0); shift_bit(1'b1); shift_bit(1'b1);
        bus.ccff_head = 1'b1; bus.ccff_shift_en = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.mem_out !== 8'h00 || bus.mem_outb !== 8'hFF) begin
            errors++; $display("FAIL midrst_mem: got %h/%h want 00/ff", bus.mem_out, bus.mem_outb); end
        checks++; if ({bus.cfg_done, bus.cfg_valid, bus.cfg_err, bus.ccff_tail} !== 4'b0000) begin
            errors++; $display("FAIL midrst_flags: got %b want 0000", {bus.cfg_done, bus.cfg_valid, bus.cfg_err, bus.ccff_tail}); end
        checks++; if (bus.bit_count !== 4'd0) begin errors++; $display("FAIL midrst_count: got %0d want 0", bus.bit_count); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        shift_byte(8'h81);
        checks++; if (bus.cfg_done !== 1'b1 || bus.bit_count !== 4'd8) begin
            errors++; $display("FAIL midrst_frame: got done=%b cnt=%0d want 1/8", bus.cfg_done, bus.bit_count); end
        commit();
        checks++; if (bus.mem_out !== 8'h81) begin errors++; $display("FAIL midrst_commit: got %h want 81", bus.mem_out); end
    endtask

    task automatic test_parity();
        do_reset();
        shift_byte(8'h01);
        commit();
`ifdef CCFF_PARITY_EN
        checks++; if (bus.mem_out !== 8'h00) begin errors++; $display("FAIL parity_odd_mem: got %h want 00", bus.mem_out); end
        checks++; if ({bus.cfg_err, bus.cfg_valid, bus.cfg_done} !== 3'b101) begin
            errors++; $display("FAIL parity_odd_flags: got %b want 101", {bus.cfg_err, bus.cfg_valid, bus.cfg_done}); end
        do_reset();
`else
        checks++; if (bus.mem_out !== 8'h01) begin errors++; $display("FAIL parity_off_mem: got %h want 01", bus.mem_out); end
        checks++; if ({bus.cfg_err, bus.cfg_valid} !== 2'b01) begin
            errors++; $display("FAIL parity_off_flags: got %b want 01", {bus.cfg_err, bus.cfg_valid}); end
`endif
        shift_byte(8'h03);
        commit();
        checks++; if (bus.mem_out !== 8'h03) begin errors++; $display("FAIL parity_even_mem: got %h want 03", bus.mem_out); end
        checks++; if (bus.cfg_valid !== 1'b1) begin errors++; $display("FAIL parity_even_valid: got %b want 1", bus.cfg_valid); end
    endtask

    initial begin
        bus.ccff_head = 1'b0; bus.ccff_shift_en = 1'b0; bus.cfg_commit = 1'b0;
        test_reset();
        test_shift();
        test_commit();
        test_early_commit();
        test_pass_through();
        test_overrun();
        test_simultaneous();
        test_midframe_reset();
        test_parity();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/grid_ccff_bank.md
GRID_CCFF_BANK -- requirements
Module: grid_ccff_bank

Interface
REQ-001 Parameter NUM_BITS, default 64, meaning number of configuration bits held by the tile; legal range 2..1024.
REQ-002 Parameter CNT_W, default $clog2(NUM_BITS+1), meaning width of the bit counter.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset; ports as follows (clock and reset first).
REQ-004 prog_clk  input  1  configuration clock; all state changes on its rising edge.
REQ-005 prog_reset  input  1  asynchronous, active-low reset.
REQ-006 ccff_head  input  1  serial configuration data in.
REQ-007 ccff_shift_en  input  1  shift strobe; one bit is accepted per cycle while high.
REQ-008 cfg_commit  input  1  single-cycle request to transfer the shift register into the active configuration.
REQ-009 ccff_tail  output  1  serial data out to the next tile; this is the shift register MSB.
REQ-010 mem_out  output  NUM_BITS  active configuration bits.
REQ-011 mem_outb  output  NUM_BITS  bitwise complement of mem_out.
REQ-012 cfg_done  output  1  high while state is LOADED.
REQ-013 cfg_valid  output  1  high once any commit has been accepted.
REQ-014 cfg_err  output  1  sticky error flag.
REQ-015 bit_count  output  CNT_W  number of bits shifted in the current frame, saturating.

Function
REQ-016 Shift register sr[NUM_BITS-1:0]: when ccff_shift_en=1, sr[0]<=ccff_head and sr[i]<=sr[i-1]. ccff_tail=sr[NUM_BITS-1], so a bit presented on ccff_head appears on ccff_tail after exactly NUM_BITS shift cycles.
REQ-017 Shifting SHALL occur in every state. The shift path SHALL never stall, so downstream tiles always receive data.
REQ-018 States are EMPTY, LOADING and LOADED.
- EMPTY -> LOADING on the first shift.
- LOADING -> LOADED on the shift that makes bit_count reach NUM_BITS.
- The state is otherwise held.
REQ-019 bit_count increments on each shift, saturates at NUM_BITS, and does not wrap.
REQ-020 A shift while bit_count==NUM_BITS (overrun) SHALL set cfg_err. The state stays LOADED.
REQ-021 Accepted commit (cfg_commit=1 while in LOADED, subject to REQ-029):
- mem_out <= sr, as it was before that edge's shift.
- cfg_valid <= 1.
- state <= EMPTY and bit_count <= 0.
- The new mem_out is visible one cycle after the commit.
REQ-022 A commit in EMPTY or LOADING SHALL be ignored: mem_out is unchanged and cfg_err is set.
REQ-023 A simultaneous commit and shift in LOADED:
- The commit is accepted using the pre-shift contents.
- The shifted bit starts a new frame: state LOADING, bit_count=1.
- cfg_err is not set.
REQ-024 mem_out SHALL change only on an accepted commit. It holds its value during shifting (double-buffered).
REQ-025 cfg_err clears only on reset.

Reset
REQ-026 Reset SHALL take effect immediately on prog_reset=0, independent of prog_clk.
REQ-027 Reset values:
- sr = 0, so ccff_tail = 0.
- mem_out = 0 and mem_outb = all ones.
- cfg_done = 0, cfg_valid = 0, cfg_err = 0, bit_count = 0.
- state = EMPTY.
REQ-028 Reset mid-frame or mid-commit SHALL discard the partial frame. The first post-reset shift starts a new frame.

Configuration
REQ-029 Macro CCFF_PARITY_EN selects commit parity checking.
- Defined: a commit in LOADED is accepted only if XOR of sr is 0 (even parity). On odd parity the commit is rejected: mem_out and cfg_valid are unchanged, the state stays LOADED, and cfg_err is set.
- Undefined: no parity logic exists, and every commit in LOADED is accepted.

Verification
REQ-030 Reset then shift: NUM_BITS=8, reset, shift 8'hA5 MSB-first -> cfg_done=1 on cycle 8, bit_count=8, mem_out=0, cfg_err=0.
REQ-031 Commit: cfg_commit after REQ-030 -> mem_out=8'hA5 and mem_outb=8'h5A next cycle, cfg_valid=1, bit_count=0, cfg_done=0.
REQ-032 Early commit and pass-through:
- cfg_commit after only 3 shifts -> cfg_err=1, mem_out unchanged.
- 16 shifts of 8'hA5 followed by 8'h3C -> ccff_tail emits 8'hA5 on cycles 9..16.
REQ-033 Overrun and simultaneous commit:
- 9th shift in LOADED -> cfg_err=1.
- Separately, commit together with a shift in LOADED -> mem_out=pre-shift sr, state LOADING, bit_count=1.
REQ-034 Mid-frame reset: prog_reset low for half a cycle at shift 5 -> all outputs at reset values immediately; the next frame of 8 bits completes normally.
REQ-035 Parity (CCFF_PARITY_EN defined):
- Commit of 8'h01 -> rejected, cfg_err=1, mem_out unchanged.
- Commit of 8'h03 -> accepted.
- With the macro undefined, 8'h01 is accepted.
